mem_access_unit: RTL and testbench
==================================

# mem_access_unit

CPU-side bus master that sits directly upstream of the 8K-word internal memory and any other slave using the same rreq/wreq/ack/busy bus. It turns CPU load/store requests (byte, halfword, word) into word-aligned bus transactions. Sub-word stores are done as read-modify-write, and loads are sign- or zero-extended. It also detects misaligned accesses and slaves that never acknowledge.

## Interface
- TIMEOUT, default 16: consecutive no-ack cycles in RD/WR before the access is aborted with an error; legal range 2..255.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- req  in  1  CPU access request; held high until `done`.
- we  in  1  1 = store, 0 = load.
- size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as misaligned.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- rdata  out  32  extended load result; valid while `done` is high.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies `done`: misaligned access or timeout.
- stall  out  1  `req & ~done`, combinational.
- bus_rreq  out  1  bus read request.
- bus_wreq  out  1  bus write request.
- bus_addr  out  32  word-aligned address, bits [1:0] always 0.
- bus_wdata  out  32  full word to write.
- bus_rdata  in  32  slave read data.
- bus_busy  in  1  slave stall.
- bus_ack  in  1  slave claims the address (combinational on the slave side).

## Operation
- **States:** IDLE, RD, WR, RESP.
- **IDLE, capture:** when `req` is high, latch `we`, `size`, `sign_ext`, `addr`, `wdata`.
  - Misaligned (`size` = 3, halfword with addr[0] = 1, word with addr[1:0] ≠ 0) → RESP with err = 1. No bus activity.
  - Load, or sub-word store → RD.
  - Word store → WR, with bus_wdata = wdata.
- **RD:** bus_rreq = 1. The transaction completes on the edge where `bus_ack & ~bus_busy`; bus_rdata is latched there.
  - Load → RESP.
  - Sub-word store → WR, with the merged word in bus_wdata: the selected lane is replaced by the low byte/half of wdata; other lanes keep the read value.
- **WR:** bus_wreq = 1. Completes on `bus_ack & ~bus_busy` → RESP.
- **RESP:** done = 1 for exactly one cycle → IDLE. A `req` still high in the following IDLE cycle is a new request.
- **Lane selection (little-endian):**
  - byte lane = addr[1:0], bits [8·addr[1:0]+7 : 8·addr[1:0]];
  - half lane = addr[1], bits [16·addr[1]+15 : 16·addr[1]].
- **Load extension:** the lane is shifted to bit 0, then the upper bits are filled with the lane MSB (`sign_ext` = 1) or with 0. Word loads pass through unchanged.
- **Timeout:**
  - An 8-bit counter clears on entry to RD/WR and on any cycle with bus_ack = 1.
  - It increments on each bus_ack = 0 cycle.
  - When it reaches TIMEOUT → RESP with err = 1; the bus request drops on that edge.
- **Bus request hold:** bus_rreq, bus_wreq, bus_addr and bus_wdata are registered and stay constant for the whole RD/WR occupancy.
- **Error response:** on err, rdata = 0 and no write was issued. An RMW that times out in RD never reaches WR.

## Timing
- **Reset values:** state IDLE, counter 0, all registered outputs 0 (bus_rreq, bus_wreq, bus_addr, bus_wdata, rdata, done, err).
- **Reset mid-operation:** on the reset edge, bus requests drop and no `done` is issued. A write already accepted by the slave on that same edge is not undone.
- **Latency, request sampled at edge 0, zero-wait slave:**
  - load word: RD in cycle 1, done in cycle 2;
  - word store: WR in cycle 1, done in cycle 2;
  - sub-word store: RD in cycle 1, WR in cycle 2, done in cycle 3;
  - misaligned: done + err in cycle 1.
- **bus_busy:** each busy cycle (ack = 1, busy = 1) extends RD/WR by one cycle. Busy cycles do not advance the timeout counter.
- bus_rreq and bus_wreq are never high in the same cycle.

## Test plan
- **Word load:** mem[0x10] = 0xDEADBEEF; load word addr 0x10, slave zero-wait → rdata = 0xDEADBEEF, done in cycle 2, err = 0.
- **Signed halfword load:** mem[0x20] = 0x8001_7F00; load half addr 0x22 with sign_ext = 1 → 0xFFFF8001; with sign_ext = 0 → 0x00008001.
- **Byte store RMW:** mem[0x30] = 0x11223344; store byte 0xAA to addr 0x31 → bus write 0x1122AA44 to 0x30, done in cycle 3.
- **Slave first-read busy:** slave asserts busy for 1 cycle on the first read → RD lasts 2 cycles, data is correct, done in cycle 3.
- **Misaligned:** word load at 0x42 → done + err in cycle 1; bus_rreq and bus_wreq stay 0 throughout.
- **Timeout:** address with no ack, TIMEOUT = 16 → done + err after 16 RD cycles, rdata = 0. Repeat as a byte store and check that bus_wreq is never asserted.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU load/store to word-bus master with RMW, load extension and timeout
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        stall,
    output logic        bus_rreq,
    output logic        bus_wreq,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_rreq_q, bus_rreq_d;
    logic        bus_wreq_q, bus_wreq_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        misaligned;
    logic        bus_done;
    logic [7:0]  cnt_inc;
    logic        timeout_hit;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign bus_done    = bus_ack & ~bus_busy;
    assign cnt_inc     = cnt_q + 8'd1;
    assign timeout_hit = ~bus_ack & (cnt_inc == TIMEOUT_CNT);

    // Alignment check on the incoming request; size 3 is never legal
    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = addr[0];
            2'd2:    misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Pick the addressed lane out of the read word and extend it to 32 bits
    always_comb begin
        byte_lane = 8'h00;
        case (addr_lo_q)
            2'd0:    byte_lane = bus_rdata[7:0];
            2'd1:    byte_lane = bus_rdata[15:8];
            2'd2:    byte_lane = bus_rdata[23:16];
            default: byte_lane = bus_rdata[31:24];
        endcase
        half_lane = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_ext  = bus_rdata;
        case (size_q)
            2'd0:    load_ext = {{24{sext_q & byte_lane[7]}}, byte_lane};
            2'd1:    load_ext = {{16{sext_q & half_lane[15]}}, half_lane};
            default: load_ext = bus_rdata;
        endcase
    end

    // Read-modify-write merge: replace only the addressed lane of the read word
    always_comb begin
        merged = bus_rdata;
        if (size_q == 2'd0) begin
            case (addr_lo_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q == 2'd1) begin
            if (addr_lo_q[1]) begin
                merged[31:16] = wdata_q;
            end else begin
                merged[15:0] = wdata_q;
            end
        end
    end

    // Next-state and registered-output logic for the access FSM
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        sext_d      = sext_q;
        addr_lo_d   = addr_lo_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        bus_rreq_d  = bus_rreq_q;
        bus_wreq_d  = bus_wreq_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d       = we;
                    size_d     = size;
                    sext_d     = sign_ext;
                    addr_lo_d  = addr[1:0];
                    wdata_d    = wdata[15:0];
                    bus_addr_d = {addr[31:2], 2'b00};
                    cnt_d      = 8'd0;
                    if (misaligned) begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else if (we && (size == 2'd2)) begin
                        state_d     = S_WR;
                        bus_wreq_d  = 1'b1;
                        bus_wdata_d = wdata;
                    end else begin
                        state_d    = S_RD;
                        bus_rreq_d = 1'b1;
                    end
                end
            end
            S_RD: begin
                if (bus_done) begin
                    bus_rreq_d = 1'b0;
                    if (we_q) begin
                        state_d     = S_WR;
                        bus_wreq_d  = 1'b1;
                        bus_wdata_d = merged;
                        cnt_d       = 8'd0;
                    end else begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        rdata_d = load_ext;
                    end
                end else if (timeout_hit) begin
                    bus_rreq_d = 1'b0;
                    state_d    = S_RESP;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    rdata_d    = 32'd0;
                end else begin
                    cnt_d = bus_ack ? 8'd0 : cnt_inc;
                end
            end
            S_WR: begin
                if (bus_done) begin
                    bus_wreq_d = 1'b0;
                    state_d    = S_RESP;
                    done_d     = 1'b1;
                    rdata_d    = 32'd0;
                end else if (timeout_hit) begin
                    bus_wreq_d = 1'b0;
                    state_d    = S_RESP;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    rdata_d    = 32'd0;
                end else begin
                    cnt_d = bus_ack ? 8'd0 : cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            sext_q      <= 1'b0;
            addr_lo_q   <= 2'd0;
            wdata_q     <= 16'd0;
            cnt_q       <= 8'd0;
            bus_rreq_q  <= 1'b0;
            bus_wreq_q  <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            addr_lo_q   <= addr_lo_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            bus_rreq_q  <= bus_rreq_d;
            bus_wreq_q  <= bus_wreq_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign rdata     = rdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign stall     = req & ~done_q;
    assign bus_rreq  = bus_rreq_q;
    assign bus_wreq  = bus_wreq_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a small bus slave model
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        stall;
    logic        bus_rreq;
    logic        bus_wreq;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_busy;
    logic        bus_ack;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .stall     (stall),
        .bus_rreq  (bus_rreq),
        .bus_wreq  (bus_wreq),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_busy  (bus_busy),
        .bus_ack   (bus_ack)
    );

    // Slave: 64 words at 0x00..0xFF acknowledge; anything else never acks
    logic [31:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_val = 32'd0;
    logic        busy_mode = 1'b0;
    logic        rreq_prev = 1'b0;
    logic [31:0] wr_addr_last = 32'd0;
    logic [31:0] wr_data_last = 32'd0;
    int          wr_count = 0;

    assign bus_ack   = (bus_rreq | bus_wreq) && (bus_addr[31:8] == 24'h0);
    assign bus_rdata = mem[bus_addr[7:2]];
    assign bus_busy  = busy_mode & bus_rreq & ~rreq_prev & bus_ack;

    always @(posedge clk) begin
        rreq_prev <= bus_rreq;
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (bus_wreq && bus_ack && !bus_busy) begin
            mem[bus_addr[7:2]] <= bus_wdata;
            wr_addr_last       <= bus_addr;
            wr_data_last       <= bus_wdata;
            wr_count           <= wr_count + 1;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cycles;
        logic        is_load;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_rc;
    int   last_wc;
    int   both_cnt = 0;
    int   unaligned_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [5:0] idx, input logic [31:0] val);
        pl_idx = idx;
        pl_val = val;
        pl_en  = 1'b1;
        @(posedge clk);
        #1;
        pl_en  = 1'b0;
    endtask

    task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_cyc);
        exp_t e;
        exp_t got;
        int   n;
        logic seen;
        e.rdata   = exp_rd;
        e.err     = exp_err;
        e.cycles  = exp_cyc;
        e.is_load = ~w;
        @(posedge clk);
        #1;
        sb_q.push_back(e);
        we       = w;
        size     = sz;
        sign_ext = sx;
        addr     = a;
        wdata    = wd;
        req      = 1'b1;
        last_rc  = 0;
        last_wc  = 0;
        seen     = 1'b0;
        n        = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus_rreq) last_rc++;
            if (bus_wreq) last_wc++;
            if (bus_rreq && bus_wreq) both_cnt++;
            if (bus_addr[1:0] != 2'b00) unaligned_cnt++;
            if (n == 1 && exp_cyc > 1) check({tag, "_stall"}, {31'd0, stall}, 32'd1);
            if (done) seen = 1'b1;
        end
        got = sb_q.pop_front();
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        if (seen) begin
            check({tag, "_err"}, {31'd0, err}, {31'd0, got.err});
            check({tag, "_cycles"}, n, got.cycles);
            if (got.is_load) check({tag, "_rdata"}, rdata, got.rdata);
            check({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        end
        req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wc_before;
        reset    = 1'b1;
        req      = 1'b0;
        we       = 1'b0;
        size     = 2'd0;
        sign_ext = 1'b0;
        addr     = 32'd0;
        wdata    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rreq", {31'd0, bus_rreq}, 32'd0);
        check("rst_wreq", {31'd0, bus_wreq}, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b0;

        poke(6'd4,  32'hDEADBEEF);
        poke(6'd8,  32'h80017F00);
        poke(6'd12, 32'h11223344);

        // loads: word, halfwords and bytes with both extensions
        access("ld_word",    1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        access("ld_h22_sx",  1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 2);
        access("ld_h22_zx",  1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'h00008001, 1'b0, 2);
        access("ld_h20_sx",  1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 32'h00007F00, 1'b0, 2);
        access("ld_b21_sx",  1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 32'h0000007F, 1'b0, 2);
        access("ld_b23_sx",  1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 2);

        // stores: byte RMW, half RMW, word
        access("st_b31", 1'b1, 2'd0, 1'b0, 32'h31, 32'h000000AA, 32'h0, 1'b0, 3);
        check("st_b31_mem", mem[12], 32'h1122AA44);
        check("st_b31_addr", wr_addr_last, 32'h30);
        check("st_b31_bus", wr_data_last, 32'h1122AA44);
        access("st_h32", 1'b1, 2'd1, 1'b0, 32'h32, 32'h1234BEEF, 32'h0, 1'b0, 3);
        check("st_h32_mem", mem[12], 32'hBEEFAA44);
        access("st_w34", 1'b1, 2'd2, 1'b0, 32'h34, 32'hCAFEF00D, 32'h0, 1'b0, 2);
        check("st_w34_mem", mem[13], 32'hCAFEF00D);
        check("st_w34_rc", last_rc, 0);
        access("ld_b31_sx", 1'b0, 2'd0, 1'b1, 32'h31, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
        access("ld_b33_zx", 1'b0, 2'd0, 1'b0, 32'h33, 32'h0, 32'h000000BE, 1'b0, 2);
        access("ld_w34",    1'b0, 2'd2, 1'b0, 32'h34, 32'h0, 32'hCAFEF00D, 1'b0, 2);

        // slave busy on first read cycle
        busy_mode = 1'b1;
        access("ld_busy", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        check("ld_busy_rc", last_rc, 2);
        busy_mode = 1'b0;

        // misaligned: no bus traffic
        access("mis_w42", 1'b0, 2'd2, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1, 1);
        check("mis_w42_rc", last_rc, 0);
        check("mis_w42_wc", last_wc, 0);
        access("mis_h43", 1'b1, 2'd1, 1'b0, 32'h43, 32'h5555, 32'h0, 1'b1, 1);
        check("mis_h43_wc", last_wc, 0);
        access("mis_sz3", 1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1);
        check("mis_sz3_rc", last_rc, 0);

        // timeouts against an address nobody acknowledges
        access("to_ld", 1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 32'h0, 1'b1, 17);
        check("to_ld_rc", last_rc, 16);
        wc_before = wr_count;
        access("to_st", 1'b1, 2'd0, 1'b0, 32'h2001, 32'hAA, 32'h0, 1'b1, 17);
        check("to_st_rc", last_rc, 16);
        check("to_st_wc", last_wc, 0);
        check("to_st_writes", wr_count, wc_before);

        // reset in the middle of a read: request drops, no done
        @(posedge clk);
        #1;
        we   = 1'b0;
        size = 2'd2;
        addr = 32'h2000;
        req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rreq_before", {31'd0, bus_rreq}, 32'd1);
        reset = 1'b1;
        req   = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rreq_after", {31'd0, bus_rreq}, 32'd0);
        check("mid_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_done_next", {31'd0, done}, 32'd0);
        access("ld_after_rst", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        check("never_both_req", both_cnt, 0);
        check("bus_addr_aligned", unaligned_cnt, 0);
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
